// File: rtl/clause_scan_scheduler_pkg.sv
// clause_scan_scheduler_pkg: shared state encoding, legal patch sizes and window-count helpers
package clause_scan_scheduler_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SCAN, S_DRAIN, S_STORE, S_DONE} state_t;
  localparam logic [2:0] PATCH_3 = 3'd3;
  localparam logic [2:0] PATCH_5 = 3'd5;
  localparam logic [2:0] PATCH_7 = 3'd7;
  function automatic int n_windows(input int dim, input int patch, input int stride);
    return (dim - patch) / stride + 1;
  endfunction
  function automatic logic cfg_legal(input logic [2:0] stride, input logic [2:0] patch);
    return stride != 3'd0 && (patch == PATCH_3 || patch == PATCH_5 || patch == PATCH_7);
  endfunction
endpackage

// File: rtl/clause_scan_scheduler_if.sv
// clause_scan_scheduler_if: host control, clause memory and engine signals of the scheduler
interface clause_scan_scheduler_if #(
  parameter int IMG_WIDTH    = 32,
  parameter int IMG_HEIGHT   = 32,
  parameter int CLAUSEN      = 10,
  parameter int CLAUSE_WIDTH = 256
);
  logic                          start;
  logic [2:0]                    cfg_stride;
  logic [2:0]                    cfg_patch;
  logic                          busy;
  logic                          done;
  logic                          err;
  logic [CLAUSEN-1:0]            result;
  logic                          mem_rd;
  logic [$clog2(CLAUSEN)-1:0]    mem_addr;
  logic [CLAUSE_WIDTH-1:0]       mem_rdata;
  logic [CLAUSE_WIDTH-1:0]       clause_write;
  logic                          valid;
  logic                          clause_act;
  logic                          img_rst;
  logic [2:0]                    stride;
  logic [2:0]                    patch_size;
  logic [7:0]                    pe_en;
  logic [IMG_WIDTH-1:0]          px_therm;
  logic [$clog2(IMG_HEIGHT)-1:0] y_base;
  logic                          ipdone;
  logic                          clause_op;
  modport master (
    input  start, cfg_stride, cfg_patch, mem_rdata, clause_op,
    output busy, done, err, result, mem_rd, mem_addr, clause_write, valid, clause_act,
           img_rst, stride, patch_size, pe_en, px_therm, y_base, ipdone
  );
  modport slave (
    output start, cfg_stride, cfg_patch, mem_rdata, clause_op,
    input  busy, done, err, result, mem_rd, mem_addr, clause_write, valid, clause_act,
           img_rst, stride, patch_size, pe_en, px_therm, y_base, ipdone
  );
endinterface

// File: rtl/clause_scan_scheduler_window_pos.sv
// window_pos_gen: patch window walker producing registered PE enables, x thermometer and last-window flag
module window_pos_gen #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          step,
  input  logic [2:0]                    stride,
  input  logic [2:0]                    patch,
  output logic [7:0]                    pe_en,
  output logic [IMG_WIDTH-1:0]          px_therm,
  output logic [$clog2(IMG_HEIGHT)-1:0] y_base,
  output logic                          last
);
  localparam int PW = $clog2(IMG_WIDTH) + 2;
  localparam int HW = $clog2(IMG_HEIGHT);
  logic [PW-1:0] s, p, x_q, x_d, y_q, y_d;
  logic on_q, on_d, col_end, row_end, last_q, last_d;
  logic [7:0] pe_en_q, pe_en_d;
  logic [IMG_WIDTH-1:0] therm_q, therm_d;
  logic [HW-1:0] yb_q, yb_d;
  assign s = PW'(stride);
  assign p = PW'(patch);
  // next window position; the walker parks on the last window and goes inactive
  always_comb begin
    col_end = x_q + s + p > PW'(IMG_WIDTH);
    row_end = y_q + (s << 3) + p > PW'(IMG_HEIGHT);
    on_d = clear || (on_q && !(step && col_end && row_end));
    x_d = clear ? '0 : (step && on_d) ? (col_end ? '0 : x_q + s) : x_q;
    y_d = clear ? '0 : (step && on_d && col_end) ? y_q + (s << 3) : y_q;
    for (int k = 0; k < 8; k++) pe_en_d[k] = on_d && (y_d + PW'(k) * s + p <= PW'(IMG_HEIGHT));
    for (int i = 0; i < IMG_WIDTH; i++) therm_d[i] = on_d && (PW'(i) < x_d);
    yb_d = on_d ? y_d[HW-1:0] : '0;
    last_d = on_d && (x_d + s + p > PW'(IMG_WIDTH)) && (y_d + (s << 3) + p > PW'(IMG_HEIGHT));
  end
  // position and decoded outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
      on_q <= 1'b0;
      pe_en_q <= '0;
      therm_q <= '0;
      yb_q <= '0;
      last_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      on_q <= on_d;
      pe_en_q <= pe_en_d;
      therm_q <= therm_d;
      yb_q <= yb_d;
      last_q <= last_d;
    end
  end
  assign pe_en = pe_en_q;
  assign px_therm = therm_q;
  assign y_base = yb_q;
  assign last = last_q;
endmodule

// File: rtl/clause_scan_scheduler.sv
// clause_scan_scheduler: fetches each clause, sweeps all windows through the engine and collects results
module clause_scan_scheduler
  import clause_scan_scheduler_pkg::*;
#(
  parameter int IMG_WIDTH    = 32,
  parameter int IMG_HEIGHT   = 32,
  parameter int CLAUSEN      = 10,
  parameter int CLAUSE_WIDTH = 256,
  parameter int DRAIN_CYC    = 3
) (
  input logic                    clk,
  input logic                    rst,
  clause_scan_scheduler_if.master bus
);
  localparam int AW = $clog2(CLAUSEN);
  localparam int DW = $clog2(DRAIN_CYC) + 1;
  state_t st_q, st_d;
  logic [AW-1:0] c_q, c_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, mem_rd_q, mem_rd_d, load_q, load_d, act_q, act_d;
  logic [CLAUSEN-1:0] result_q, result_d;
  logic [CLAUSE_WIDTH-1:0] cw_q, cw_d;
  logic [2:0] stride_q, stride_d, patch_q, patch_d;
  logic legal, ipdone;
  window_pos_gen #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_pos (
    .clk, .rst,
    .clear(st_q == S_LOAD),
    .step(st_q == S_SCAN),
    .stride(stride_q),
    .patch(patch_q),
    .pe_en(bus.pe_en),
    .px_therm(bus.px_therm),
    .y_base(bus.y_base),
    .last(ipdone)
  );
  // sequencing and registered-output next values; load strobe lands with the captured word
  always_comb begin
    legal = cfg_legal(bus.cfg_stride, bus.cfg_patch);
    st_d = st_q;
    c_d = c_q;
    dcnt_d = dcnt_q;
    err_d = err_q;
    result_d = result_q;
    stride_d = stride_q;
    patch_d = patch_q;
    case (st_q)
      S_IDLE: if (bus.start) begin
        st_d = legal ? S_FETCH : S_DONE;
        err_d = !legal;
        c_d = '0;
        result_d = '0;
        stride_d = bus.cfg_stride;
        patch_d = bus.cfg_patch;
      end
      S_FETCH: st_d = S_LOAD;
      S_LOAD: st_d = S_SCAN;
      S_SCAN: begin
        dcnt_d = '0;
        st_d = ipdone ? S_DRAIN : S_SCAN;
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        st_d = (dcnt_q == DW'(DRAIN_CYC - 1)) ? S_STORE : S_DRAIN;
      end
      S_STORE: begin
        result_d[c_q] = bus.clause_op;
        c_d = c_q + 1'b1;
        st_d = (c_q == AW'(CLAUSEN - 1)) ? S_DONE : S_FETCH;
      end
      default: st_d = S_IDLE;
    endcase
    busy_d = st_d != S_IDLE;
    done_d = st_q == S_DONE;
    mem_rd_d = st_d == S_FETCH;
    load_d = st_q == S_LOAD;
    cw_d = (st_q == S_LOAD) ? bus.mem_rdata : cw_q;
    act_d = st_d == S_SCAN || st_d == S_DRAIN;
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= S_IDLE;
      c_q <= '0;
      dcnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      mem_rd_q <= 1'b0;
      load_q <= 1'b0;
      act_q <= 1'b0;
      result_q <= '0;
      cw_q <= '0;
      stride_q <= '0;
      patch_q <= '0;
    end else begin
      st_q <= st_d;
      c_q <= c_d;
      dcnt_q <= dcnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      mem_rd_q <= mem_rd_d;
      load_q <= load_d;
      act_q <= act_d;
      result_q <= result_d;
      cw_q <= cw_d;
      stride_q <= stride_d;
      patch_q <= patch_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.result = result_q;
  assign bus.mem_rd = mem_rd_q;
  assign bus.mem_addr = c_q;
  assign bus.clause_write = cw_q;
  assign bus.valid = load_q;
  assign bus.img_rst = load_q;
  assign bus.clause_act = act_q;
  assign bus.stride = stride_q;
  assign bus.patch_size = patch_q;
  assign bus.ipdone = ipdone;
endmodule
